acc_group_sched: RTL and testbench
==================================

# acc_group_sched

Issue controller for the grouped-accumulate forwarding datapath. It watches the local-sum FIFO that feeds the accumulator, pops one whole group of beats per issue, and drives the datapath's enable, valid and length-mode inputs. Every group therefore reaches the accumulator as an unbroken run of valid beats with a constant mode. It also tracks the 12-stage in-flight window so that flushes and idle detection are exact.

## Interface
- `ACC_LAT`, 12: datapath pipeline depth in enabled cycles.
- `CNT_W`, 5: width of the FIFO occupancy input.
- `PERF_W`, 32: width of the performance counters.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_fifo_count`  in  CNT_W  entries in the local-sum FIFO.
- `i_fifo_mode`  in  4  length mode of the FIFO head entry (the first beat of the next group).
- `o_fifo_pop`  out  1  pops the FIFO head; identical to `o_acc_valid`.
- `i_out_ready`  in  1  downstream can accept datapath output.
- `o_acc_en`  out  1  datapath global enable; equals `i_out_ready`.
- `o_acc_valid`  out  1  datapath valid-sum input.
- `o_acc_mode`  out  4  datapath length-mode input; the latched group mode.
- `i_flush`  in  1  single-cycle flush request.
- `o_flush_done`  out  1  single-cycle pulse when a flush completes.
- `o_idle`  out  1  state is IDLE and nothing is in flight.
- `o_err_mode`  out  1  sticky flag: an illegal mode (14 or 15) was accepted.
- `o_perf_beats`, `o_perf_groups`, `o_perf_bubbles`  out  PERF_W  performance counters.

## Operation
- Group size G(m):
  - modes 0–2: G = 1.
  - modes 3–13: G = m−1 (range 2..12).
  - modes 14–15: G = 1, treated as mode 0, and `o_err_mode` is set.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - With `flush_pend` set, go to DRAIN.
  - Otherwise, if `i_fifo_count` ≥ G(`i_fifo_mode`) and `i_out_ready`, latch mode and set `beats_left` = G, then go to ISSUE.
  - Never issues a beat.
- ISSUE:
  - Each cycle with `i_out_ready`: `o_acc_valid` = `o_fifo_pop` = 1 and `beats_left` decrements.
  - When `beats_left` reaches 0: go to DRAIN if `flush_pend` is set, else go to IDLE.
  - With `i_out_ready` low: no beat is issued, state holds, and the datapath freezes because `o_acc_en` = 0. The group is stalled, not broken.
- DRAIN:
  - Wait until the in-flight tracker is all-zero.
  - Then pulse `o_flush_done`, clear `flush_pend`, and go to IDLE.
- Flush requests:
  - `flush_pend` is set by `i_flush` in any state.
  - A flush raised in ISSUE takes effect only at the group boundary.
  - `i_flush` while `flush_pend` is already set is absorbed.
- In-flight tracker: an `ACC_LAT`-bit shift register that shifts in `o_acc_valid` only when `o_acc_en` = 1.
- `o_idle` = (state == IDLE) & tracker == 0 & ~`flush_pend`.
- `o_acc_mode` holds the latched mode outside ISSUE. Value 0 after reset.

## Timing
- Reset (async assert, sync deassert):
  - state IDLE, tracker 0, `flush_pend` 0, `beats_left` 0, latched mode 0, `o_err_mode` 0, counters 0.
  - Resulting outputs: `o_fifo_pop`, `o_acc_valid`, `o_flush_done` = 0; `o_acc_mode` = 0; `o_idle` = 1. `o_acc_en` follows `i_out_ready`.
- Issue timing:
  - The IDLE decision is made in cycle t.
  - The first beat issues in cycle t+1; the group occupies t+1..t+G with no stalls.
  - There is a minimum one-cycle bubble between consecutive groups (the IDLE cycle).
- Datapath result leaves `ACC_LAT` enabled cycles after the beat that issued it.
- `o_flush_done` asserts `ACC_LAT`+1 cycles after the last issued beat, with no stalls.
- `o_acc_valid`, `o_fifo_pop` and `o_acc_en` are combinational from state and `i_out_ready`. All other outputs are registered.
- Reset asserted mid-group drops the partial group. Popped entries are not restored.

## Configuration
- `ACC_SCHED_PERF_EN` defined:
  - beats: +1 per issued beat.
  - groups: +1 per ISSUE entry.
  - bubbles: +1 per enabled IDLE cycle with `i_fifo_count` > 0.
  - All counters wrap at 2^PERF_W.
- `ACC_SCHED_PERF_EN` undefined: the counter registers are absent and the three outputs are tied to 0.

## Structure
- Shared package `acc_pkg` holds:
  - `ACC_LAT`;
  - the `acc_mode_t` 4-bit typedef;
  - the state enum (IDLE / ISSUE / DRAIN);
  - function `acc_group_size(acc_mode_t)`, which returns the 4-bit G and is shared with the datapath owner.
- Sub-module `acc_inflight_tracker` contains the enabled shift register and the empty flag.

## Test plan
- Mode 5 with count 4, always ready:
  - beats issue in 4 consecutive cycles with `o_acc_mode` = 5;
  - no pop in the IDLE cycle before or after;
  - perf groups = 1, beats = 4.
- Mode 13 with count 11 → no issue; count raised to 12 → 12 contiguous beats.
- Mode 4 group with `i_out_ready` low for 3 cycles after beat 1 → pop and `o_acc_en` low for those cycles; beats 2–3 follow and the group completes intact.
- `i_flush` during beat 2 of a mode 6 group → remaining beats issue, then DRAIN; `o_flush_done` pulses 13 cycles after the last beat; `o_idle` = 1 after.
- Mode 15 at the head, count 1 → a single beat issues with `o_acc_mode` = 0; `o_err_mode` sets and stays set.
- `i_rst_n` low mid-group (beat 3 of 8) → all outputs reach reset values immediately; after release, with no FIFO data, `o_idle` = 1.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the grouped-accumulate datapath and its issue controller.
package acc_pkg;

  localparam int unsigned ACC_LAT = 12;
  localparam int unsigned MODE_W  = 4;

  typedef logic [MODE_W-1:0] acc_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } acc_state_t;

  // Beats per group for a length mode; illegal modes behave like mode 0.
  function automatic logic [3:0] acc_group_size(acc_mode_t mode);
    if (mode >= 4'd3 && mode <= 4'd13) begin
      return mode - 4'd1;
    end
    return 4'd1;
  endfunction

  function automatic logic acc_mode_illegal(acc_mode_t mode);
    return mode >= 4'd14;
  endfunction

endpackage

// File: rtl/acc_group_sched_if.sv
// FIFO-side and datapath-side handshake bundle of the group issue controller.
interface acc_group_sched_if #(
  parameter int unsigned CNT_W = 5
);
  import acc_pkg::*;

  logic [CNT_W-1:0] i_fifo_count;
  acc_mode_t        i_fifo_mode;
  logic             o_fifo_pop;
  logic             i_out_ready;
  logic             o_acc_en;
  logic             o_acc_valid;
  acc_mode_t        o_acc_mode;

  modport master (
    input  i_fifo_count, i_fifo_mode, i_out_ready,
    output o_fifo_pop, o_acc_en, o_acc_valid, o_acc_mode
  );

  modport slave (
    output i_fifo_count, i_fifo_mode, i_out_ready,
    input  o_fifo_pop, o_acc_en, o_acc_valid, o_acc_mode
  );

endinterface

// File: rtl/acc_inflight_tracker.sv
// Enable-gated shift register mirroring the datapath's in-flight valid beats.
module acc_inflight_tracker #(
  parameter int unsigned LAT = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_valid,
  output logic o_empty,
  output logic o_empty_next
);

  logic [LAT-1:0] trk_q;
  logic [LAT-1:0] trk_d;

  assign trk_d        = i_en ? {trk_q[LAT-2:0], i_valid} : trk_q;
  assign o_empty      = (trk_q == '0);
  assign o_empty_next = (trk_d == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trk_q <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

endmodule

// File: rtl/acc_group_sched.sv
// Group issue controller for the accumulate datapath.
// Optional performance counters: define ACC_SCHED_PERF_EN.
module acc_group_sched
  import acc_pkg::*;
#(
  parameter int unsigned ACC_LAT = acc_pkg::ACC_LAT,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  acc_group_sched_if.master bus,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic              o_idle,
  output logic              o_err_mode,
  output logic [PERF_W-1:0] o_perf_beats,
  output logic [PERF_W-1:0] o_perf_groups,
  output logic [PERF_W-1:0] o_perf_bubbles
);

  acc_state_t state;
  logic [3:0] beats_left;
  acc_mode_t  mode_q;
  logic       flush_pend;
  logic       flush_done_q;
  logic       err_q;
  logic [3:0] head_size;
  logic       start;
  logic       trk_empty;
  logic       trk_empty_next;

  assign head_size = acc_group_size(bus.i_fifo_mode);
  assign start     = (state == IDLE) && !flush_pend && bus.i_out_ready &&
                     (bus.i_fifo_count >= CNT_W'(head_size));

  // Beats are issued straight from state so a stalled group resumes without a gap.
  assign bus.o_acc_en    = bus.i_out_ready;
  assign bus.o_acc_valid = (state == ISSUE) && bus.i_out_ready;
  assign bus.o_fifo_pop  = bus.o_acc_valid;
  assign bus.o_acc_mode  = mode_q;

  assign o_flush_done = flush_done_q;
  assign o_err_mode   = err_q;
  assign o_idle       = (state == IDLE) && trk_empty && !flush_pend;

  acc_inflight_tracker #(.LAT(ACC_LAT)) u_tracker (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (bus.o_acc_en),
    .i_valid      (bus.o_acc_valid),
    .o_empty      (trk_empty),
    .o_empty_next (trk_empty_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      beats_left   <= '0;
      mode_q       <= '0;
      flush_pend   <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (i_flush) begin
        flush_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (flush_pend) begin
            state <= DRAIN;
          end else if (start) begin
            state      <= ISSUE;
            beats_left <= head_size;
            mode_q     <= acc_mode_illegal(bus.i_fifo_mode) ? '0 : bus.i_fifo_mode;
            if (acc_mode_illegal(bus.i_fifo_mode)) begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.i_out_ready) begin
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) begin
              state <= flush_pend ? DRAIN : IDLE;
            end
          end
        end
        DRAIN: begin
          // Completion coincides with the last in-flight beat leaving the window.
          if (trk_empty_next) begin
            flush_done_q <= 1'b1;
            flush_pend   <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_SCHED_PERF_EN
  logic [PERF_W-1:0] beats_q;
  logic [PERF_W-1:0] groups_q;
  logic [PERF_W-1:0] bubbles_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beats_q   <= '0;
      groups_q  <= '0;
      bubbles_q <= '0;
    end else begin
      beats_q   <= beats_q + PERF_W'(bus.o_acc_valid);
      groups_q  <= groups_q + PERF_W'(start);
      bubbles_q <= bubbles_q + PERF_W'((state == IDLE) && bus.i_out_ready &&
                                       (bus.i_fifo_count != '0));
    end
  end

  assign o_perf_beats   = beats_q;
  assign o_perf_groups  = groups_q;
  assign o_perf_bubbles = bubbles_q;
`else
  assign o_perf_beats   = '0;
  assign o_perf_groups  = '0;
  assign o_perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_acc_group_sched.sv
// Self-checking bench for acc_group_sched: directed scenarios plus a randomized
// FIFO/ready run checked against a queue-based group model.
module tb_acc_group_sched;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PERF_W = 32;
  localparam int unsigned LAT    = 12;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_flush;
  logic              o_flush_done;
  logic              o_idle;
  logic              o_err_mode;
  logic [PERF_W-1:0] o_perf_beats;
  logic [PERF_W-1:0] o_perf_groups;
  logic [PERF_W-1:0] o_perf_bubbles;

  acc_group_sched_if #(.CNT_W(CNT_W)) bus ();

  acc_group_sched #(.ACC_LAT(LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .bus            (bus.master),
    .i_flush        (i_flush),
    .o_flush_done   (o_flush_done),
    .o_idle         (o_idle),
    .o_err_mode     (o_err_mode),
    .o_perf_beats   (o_perf_beats),
    .o_perf_groups  (o_perf_groups),
    .o_perf_bubbles (o_perf_bubbles)
  );

  always #5 i_clk = ~i_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] fifo_q[$];
  logic [3:0] dummy;
  logic       s_valid, s_pop, s_en, s_done, s_idle, s_err;
  logic [3:0] s_mode;

  function automatic int ref_group(logic [3:0] m);
    if (m >= 4'd3 && m <= 4'd13) return int'(m) - 1;
    return 1;
  endfunction

  function automatic logic [3:0] ref_mode(logic [3:0] m);
    return (m >= 4'd14) ? 4'd0 : m;
  endfunction

  task automatic apply_fifo();
    bus.i_fifo_count = CNT_W'(fifo_q.size());
    bus.i_fifo_mode  = (fifo_q.size() > 0) ? fifo_q[0] : 4'd0;
  endtask

  // One clock: sample at negedge, then emulate the FIFO pop after the edge.
  task automatic step();
    @(negedge i_clk);
    s_valid = bus.o_acc_valid;
    s_pop   = bus.o_fifo_pop;
    s_en    = bus.o_acc_en;
    s_mode  = bus.o_acc_mode;
    s_done  = o_flush_done;
    s_idle  = o_idle;
    s_err   = o_err_mode;
    @(posedge i_clk);
    #1;
    if (s_pop && fifo_q.size() > 0) dummy = fifo_q.pop_front();
    apply_fifo();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    bus.i_out_ready = 1'b0;
    fifo_q.delete();
    apply_fifo();
    repeat (3) @(posedge i_clk);
    #1;
    n_tests++;
    if ({bus.o_acc_valid, bus.o_fifo_pop, o_flush_done, o_idle, o_err_mode} !== 5'b00010) begin
      n_fail++;
      $display("FAIL rst_flags got=%b exp=00010",
               {bus.o_acc_valid, bus.o_fifo_pop, o_flush_done, o_idle, o_err_mode});
    end
    n_tests++;
    if (bus.o_acc_mode !== 4'd0) begin
      n_fail++; $display("FAIL rst_mode got=%0d exp=0", bus.o_acc_mode);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.o_acc_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_en_hi got=%b exp=1", bus.o_acc_en);
    end
    bus.i_out_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.o_acc_en, o_idle} !== 2'b01) begin
      n_fail++; $display("FAIL rst_en_lo got=%b exp=01", {bus.o_acc_en, o_idle});
    end
    n_tests++;
    if ({o_perf_beats, o_perf_groups, o_perf_bubbles} !== '0) begin
      n_fail++;
      $display("FAIL rst_perf got=%0d/%0d/%0d exp=0/0/0", o_perf_beats, o_perf_groups, o_perf_bubbles);
    end
    bus.i_out_ready = 1'b1;
  endtask

  task automatic test_mode5();
    logic [31:0] eb, eg, ebub;
    fifo_q = {4'd5, 4'd5, 4'd5, 4'd5};
    apply_fifo();
    bus.i_out_ready = 1'b1;
    step();
    n_tests++;
    if ({s_valid, s_pop} !== 2'b00) begin
      n_fail++; $display("FAIL m5_pre got=%b exp=00", {s_valid, s_pop});
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_pop, s_mode} !== {2'b11, 4'd5}) begin
        n_fail++; $display("FAIL m5_beat%0d got=%b/%0d exp=11/5", i, {s_valid, s_pop}, s_mode);
      end
    end
    step();
    n_tests++;
    if ({s_valid, s_pop} !== 2'b00) begin
      n_fail++; $display("FAIL m5_post got=%b exp=00", {s_valid, s_pop});
    end
`ifdef ACC_SCHED_PERF_EN
    eb = 32'd4; eg = 32'd1; ebub = 32'd1;
`else
    eb = 32'd0; eg = 32'd0; ebub = 32'd0;
`endif
    n_tests++;
    if ({o_perf_beats, o_perf_groups, o_perf_bubbles} !== {eb, eg, ebub}) begin
      n_fail++;
      $display("FAIL m5_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               o_perf_beats, o_perf_groups, o_perf_bubbles, eb, eg, ebub);
    end
  endtask

  task automatic test_mode13_threshold();
    fifo_q.delete();
    repeat (11) fifo_q.push_back(4'd13);
    apply_fifo();
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_pop} !== 2'b00) begin
        n_fail++; $display("FAIL m13_hold%0d got=%b exp=00", i, {s_valid, s_pop});
      end
    end
    fifo_q.push_back(4'd13);
    apply_fifo();
    step();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL m13_decide got=%b exp=0", s_valid);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_pop, s_mode} !== {2'b11, 4'd13}) begin
        n_fail++; $display("FAIL m13_beat%0d got=%b/%0d exp=11/13", i, {s_valid, s_pop}, s_mode);
      end
    end
    step();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL m13_post got=%b exp=0", s_valid);
    end
  endtask

  task automatic test_stall();
    fifo_q = {4'd4, 4'd4, 4'd4};
    apply_fifo();
    bus.i_out_ready = 1'b1;
    step();
    step();
    n_tests++;
    if ({s_valid, s_pop, s_mode} !== {2'b11, 4'd4}) begin
      n_fail++; $display("FAIL stall_beat1 got=%b/%0d exp=11/4", {s_valid, s_pop}, s_mode);
    end
    bus.i_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_pop, s_en} !== 3'b000) begin
        n_fail++; $display("FAIL stall_hold%0d got=%b exp=000", i, {s_valid, s_pop, s_en});
      end
    end
    bus.i_out_ready = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_pop, s_en, s_mode} !== {3'b111, 4'd4}) begin
        n_fail++;
        $display("FAIL stall_beat%0d got=%b/%0d exp=111/4", i, {s_valid, s_pop, s_en}, s_mode);
      end
    end
    step();
    n_tests++;
    if ({s_valid, fifo_q.size() == 0} !== 2'b01) begin
      n_fail++; $display("FAIL stall_end got=%b exp=01", {s_valid, fifo_q.size() == 0});
    end
  endtask

  task automatic test_flush();
    fifo_q = {4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
    apply_fifo();
    bus.i_out_ready = 1'b1;
    step();
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_mode} !== {1'b1, 4'd6}) begin
        n_fail++; $display("FAIL flush_beat%0d got=%b/%0d exp=1/6", i, s_valid, s_mode);
      end
    end
    for (int k = 1; k <= 14; k++) begin
      step();
      n_tests++;
      if ({s_valid, s_done, s_idle} !== {1'b0, k == 13, k >= 13}) begin
        n_fail++;
        $display("FAIL flush_k%0d got=%b exp=%b", k, {s_valid, s_done, s_idle},
                 {1'b0, k == 13, k >= 13});
      end
    end
  endtask

  task automatic test_illegal_mode();
    n_tests++;
    if (o_err_mode !== 1'b0) begin
      n_fail++; $display("FAIL err_pre got=%b exp=0", o_err_mode);
    end
    fifo_q = {4'd15};
    apply_fifo();
    step();
    step();
    n_tests++;
    if ({s_valid, s_mode, s_err} !== {1'b1, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL err_beat got=%b/%0d/%b exp=1/0/1", s_valid, s_mode, s_err);
    end
    step();
    n_tests++;
    if ({s_valid, s_err} !== 2'b01) begin
      n_fail++; $display("FAIL err_after got=%b exp=01", {s_valid, s_err});
    end
    fifo_q = {4'd1};
    apply_fifo();
    step();
    step();
    n_tests++;
    if ({s_valid, s_mode, s_err} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL err_sticky got=%b/%0d/%b exp=1/1/1", s_valid, s_mode, s_err);
    end
  endtask

  task automatic test_random();
    int         in_grp = 0;
    int         rem    = 0;
    logic [3:0] emode  = 4'd0;
    logic       exp_v;
    logic [3:0] e_mode;
    logic       rdy;
    fifo_q.delete();
    for (int c = 0; c < 600; c++) begin
      rdy = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.i_out_ready = rdy;
      if (c < 400 && fifo_q.size() < 31 && $urandom_range(0, 1) == 1)
        fifo_q.push_back(4'($urandom_range(0, 15)));
      if (c >= 400 && in_grp == 0 && fifo_q.size() > 0 && fifo_q.size() < ref_group(fifo_q[0]))
        fifo_q.push_back(4'd0);
      apply_fifo();
      exp_v  = (in_grp != 0) && rdy;
      e_mode = emode;
      if (in_grp != 0) begin
        if (rdy) begin
          rem--;
          if (rem == 0) in_grp = 0;
        end
      end else if (rdy && fifo_q.size() > 0 && fifo_q.size() >= ref_group(fifo_q[0])) begin
        in_grp = 1;
        rem    = ref_group(fifo_q[0]);
        emode  = ref_mode(fifo_q[0]);
      end
      step();
      n_tests++;
      if ({s_valid, s_pop, s_en} !== {exp_v, exp_v, rdy}) begin
        n_fail++; $display("FAIL rnd_c%0d got=%b exp=%b", c, {s_valid, s_pop, s_en}, {exp_v, exp_v, rdy});
      end
      if (exp_v) begin
        n_tests++;
        if (s_mode !== e_mode) begin
          n_fail++; $display("FAIL rnd_mode_c%0d got=%0d exp=%0d", c, s_mode, e_mode);
        end
      end
    end
    n_tests++;
    if (in_grp != 0 || fifo_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain got=%0d/%0d exp=0/0", in_grp, fifo_q.size());
    end
    repeat (LAT + 2) step();
    n_tests++;
    if ({s_valid, s_idle} !== 2'b01) begin
      n_fail++; $display("FAIL rnd_idle got=%b exp=01", {s_valid, s_idle});
    end
  endtask

  task automatic test_reset_mid_group();
    fifo_q.delete();
    repeat (8) fifo_q.push_back(4'd9);
    apply_fifo();
    bus.i_out_ready = 1'b1;
    step();
    for (int i = 1; i <= 2; i++) begin
      step();
      n_tests++;
      if ({s_valid, s_mode} !== {1'b1, 4'd9}) begin
        n_fail++; $display("FAIL rstm_beat%0d got=%b/%0d exp=1/9", i, s_valid, s_mode);
      end
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.o_acc_valid, bus.o_fifo_pop, o_flush_done, o_idle, o_err_mode, bus.o_acc_mode}
        !== {5'b00010, 4'd0}) begin
      n_fail++;
      $display("FAIL rstm_async got=%b/%0d exp=00010/0",
               {bus.o_acc_valid, bus.o_fifo_pop, o_flush_done, o_idle, o_err_mode}, bus.o_acc_mode);
    end
    n_tests++;
    if ({o_perf_beats, o_perf_groups, o_perf_bubbles} !== '0) begin
      n_fail++;
      $display("FAIL rstm_perf got=%0d/%0d/%0d exp=0/0/0", o_perf_beats, o_perf_groups, o_perf_bubbles);
    end
    fifo_q.delete();
    apply_fifo();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({s_valid, s_idle, s_err} !== 3'b010) begin
      n_fail++; $display("FAIL rstm_idle got=%b exp=010", {s_valid, s_idle, s_err});
    end
  endtask

  initial begin
    test_reset();
    test_mode5();
    test_mode13_threshold();
    test_stall();
    test_flush();
    test_illegal_mode();
    test_random();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
